// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions.
//   DEF_DATA_WIDTH : default two's-complement width on the VNU side
//   SM_WIDTH       : sign-magnitude message width (sign bit + magnitude)
//   sm_msg_t       : sign-magnitude message at the default width
//   cnu_state_t    : serial check node phase
//   MAG_MAX        : all-ones magnitude, the "no minimum yet" marker
package ldpc_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 6;
    localparam int unsigned SM_WIDTH       = DEF_DATA_WIDTH + 1;

    typedef logic [SM_WIDTH-1:0] sm_msg_t;

    typedef enum logic {
        COLLECT,
        EMIT
    } cnu_state_t;

    localparam logic [DEF_DATA_WIDTH-1:0] MAG_MAX = {DEF_DATA_WIDTH{1'b1}};

endpackage

// File: rtl/cnu_min2_update.sv
// Combinational two-smallest tracker: folds one new magnitude into the running
// (min1, min2, min_idx) triple. Comparisons are strict, so the earliest edge
// keeps min1 on a tie and the equal later magnitude lands in min2.
// Ports:
//   min1_i, min2_i, min_idx_i : current smallest, second smallest, index of smallest
//   mag_i, idx_i              : new magnitude and its edge index
//   min1_o, min2_o, min_idx_o : updated triple
module cnu_min2_update #(
    parameter int unsigned MAG_W = 6,
    parameter int unsigned IDX_W = 3
) (
    input  logic [MAG_W-1:0] min1_i,
    input  logic [MAG_W-1:0] min2_i,
    input  logic [IDX_W-1:0] min_idx_i,
    input  logic [MAG_W-1:0] mag_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [MAG_W-1:0] min1_o,
    output logic [MAG_W-1:0] min2_o,
    output logic [IDX_W-1:0] min_idx_o
);

    always_comb begin
        min1_o    = min1_i;
        min2_o    = min2_i;
        min_idx_o = min_idx_i;
        if (mag_i < min1_i) begin
            min2_o    = min1_i;
            min1_o    = mag_i;
            min_idx_o = idx_i;
        end else if (mag_i < min2_i) begin
            min2_o = mag_i;
        end
    end

endmodule

// File: rtl/cnu_serial_min_sum.sv
// Serial min-sum check node unit. Collects DEGREE sign-magnitude V2C messages
// one per cycle, then emits DEGREE sign-magnitude C2V messages one per
// out_ready cycle, with optional offset correction.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (ready only while collecting)
//   in_data             : V2C message {sign, magnitude}
//   out_valid/out_ready : output handshake (valid only while emitting)
//   out_data            : C2V message {sign, magnitude}
//   out_last            : marks edge DEGREE-1 of a frame
module cnu_serial_min_sum
    import ldpc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEGREE     = 6,
    parameter int unsigned OFFSET     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic                  out_last
);

    localparam int unsigned            IDX_W    = $clog2(DEGREE);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DEGREE - 1);
    localparam logic [DATA_WIDTH-1:0]  OFF      = DATA_WIDTH'(OFFSET);
    localparam logic [DATA_WIDTH-1:0]  ONES     = {DATA_WIDTH{1'b1}};

    cnu_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   sign_acc_q, sign_acc_d;
    logic [DEGREE-1:0]      sign_mem_q, sign_mem_d;
    logic [DATA_WIDTH-1:0]  min1_q, min1_d;
    logic [DATA_WIDTH-1:0]  min2_q, min2_d;
    logic [IDX_W-1:0]       min_idx_q, min_idx_d;

    logic                   in_sign;
    logic [DATA_WIDTH-1:0]  in_mag;
    logic [DATA_WIDTH-1:0]  upd_min1, upd_min2;
    logic [IDX_W-1:0]       upd_min_idx;
    logic [DATA_WIDTH-1:0]  sel_mag, emit_mag;
    logic                   emit_sign;

    assign in_sign = in_data[DATA_WIDTH];
    assign in_mag  = in_data[DATA_WIDTH-1:0];

    cnu_min2_update #(
        .MAG_W (DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_min2 (
        .min1_i    (min1_q),
        .min2_i    (min2_q),
        .min_idx_i (min_idx_q),
        .mag_i     (in_mag),
        .idx_i     (idx_q),
        .min1_o    (upd_min1),
        .min2_o    (upd_min2),
        .min_idx_o (upd_min_idx)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sign_acc_d = sign_acc_q;
        sign_mem_d = sign_mem_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        min_idx_d  = min_idx_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_acc_d        = sign_acc_q ^ in_sign;
                    sign_mem_d[idx_q] = in_sign;
                    min1_d            = upd_min1;
                    min2_d            = upd_min2;
                    min_idx_d         = upd_min_idx;
                    if (idx_q == LAST_IDX) begin
                        state_d = EMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = COLLECT;
                        idx_d      = '0;
                        sign_acc_d = 1'b0;
                        min1_d     = ONES;
                        min2_d     = ONES;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    // Outputs come only from registers, so they hold still under backpressure.
    always_comb begin
        sel_mag   = (idx_q == min_idx_q) ? min2_q : min1_q;
        emit_mag  = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
        emit_sign = sign_acc_q ^ sign_mem_q[idx_q];
        out_data  = (state_q == EMIT) ? {emit_sign, emit_mag} : '0;
        out_last  = (state_q == EMIT) && (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            sign_acc_q <= 1'b0;
            sign_mem_q <= '0;
            min1_q     <= ONES;
            min2_q     <= ONES;
            min_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sign_acc_q <= sign_acc_d;
            sign_mem_q <= sign_mem_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            min_idx_q  <= min_idx_d;
        end
    end

endmodule

// File: tb/tb_cnu_serial_min_sum.sv
module tb_cnu_serial_min_sum;

    localparam int DW  = 6;
    localparam int DEG = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW:0]   in_data;
    logic          out_ready;
    logic          in_ready0, out_valid0, out_last0;
    logic          in_ready1, out_valid1, out_last1;
    logic [DW:0]   out_data0, out_data1;

    // Two instances share all stimulus: one plain min-sum, one with offset 1.
    cnu_serial_min_sum #(.DATA_WIDTH(DW), .DEGREE(DEG), .OFFSET(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0),
        .out_last  (out_last0)
    );

    cnu_serial_min_sum #(.DATA_WIDTH(DW), .DEGREE(DEG), .OFFSET(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .out_last  (out_last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected entries: {last, sign, magnitude[5:0]}
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int cur_mag[DEG];
    int cur_sgn[DEG];

    bit rand_ready = 0;
    bit bp_arm     = 0;
    int bp_cnt     = 0;
    int edge_ctr   = 0;

    // Reference: parity of all signs; smallest magnitude (earliest on ties);
    // smallest of the remaining edges; each edge sees the minimum of the others.
    task automatic push_expected();
        int acc, i1, m1, m2, m, mg;
        acc = 0;
        i1  = 0;
        for (int j = 0; j < DEG; j++) begin
            acc ^= cur_sgn[j];
            if (cur_mag[j] < cur_mag[i1]) i1 = j;
        end
        m1 = cur_mag[i1];
        m2 = 1 << DW;
        for (int j = 0; j < DEG; j++)
            if (j != i1 && cur_mag[j] < m2) m2 = cur_mag[j];
        for (int e = 0; e < DEG; e++) begin
            m = (e == i1) ? m2 : m1;
            exp_q0.push_back({1'(e == DEG - 1), 1'(acc ^ cur_sgn[e]), 6'(m)});
            mg = (m > 1) ? m - 1 : 0;
            exp_q1.push_back({1'(e == DEG - 1), 1'(acc ^ cur_sgn[e]), 6'(mg)});
        end
    endtask

    // Drives cur_mag/cur_sgn. Stops before beat stop_at (DEG = full frame).
    task automatic send_frame(input int max_gap, input int stop_at);
        bit acc_seen;
        int budget;
        for (int e = 0; e < DEG; e++) begin
            if (e == stop_at) break;
            if (max_gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (e == DEG - 1) push_expected();
            in_valid = 1'b1;
            in_data  = {1'(cur_sgn[e]), 6'(cur_mag[e])};
            budget   = 0;
            acc_seen = 1'b0;
            while (!acc_seen && budget < 200) begin
                acc_seen = in_ready0;
                @(posedge clk);
                #1;
                budget++;
            end
            in_valid = 1'b0;
            if (!acc_seen) check("in_ready_timeout", 0, 1);
            if (e == DEG - 1) begin
                check("latency_out_valid0", out_valid0, 1);
                check("latency_out_valid1", out_valid1, 1);
            end
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((exp_q0.size() != 0 || !in_ready0) && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_timeout", int'(exp_q0.size() == 0 && in_ready0), 1);
    endtask

    task automatic set_frame(input int m0, m1, m2, m3, m4, m5,
                             input int s0, s1, s2, s3, s4, s5);
        cur_mag = '{m0, m1, m2, m3, m4, m5};
        cur_sgn = '{s0, s1, s2, s3, s4, s5};
    endtask

    // out_ready driver, optionally forcing a 5-cycle stall on edge 2.
    always @(posedge clk) begin
        #1;
        if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt--;
        end else if (bp_arm && out_valid0 && edge_ctr == 2) begin
            out_ready = 1'b0;
            bp_cnt    = 4;
            bp_arm    = 0;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    bit          stall_q   = 0;
    logic [DW:0] held0, held1;
    bit          after_last = 0;

    always @(negedge clk) begin
        logic [7:0] e0, e1;
        if (!rst_n) begin
            check("rst_in_ready", in_ready0, 1);
            check("rst_out_valid", out_valid0, 0);
            check("rst_out_data", out_data0, 0);
            check("rst_out_last", out_last0, 0);
            check("rst_out_valid1", out_valid1, 0);
            stall_q    = 0;
            after_last = 0;
            edge_ctr   = 0;
        end else begin
            check("phase_exclusive", in_ready0, int'(!out_valid0));
            check("dut_align", out_valid1, out_valid0);
            if (after_last) begin
                check("in_ready_after_last", in_ready0, 1);
                after_last = 0;
            end
            if (stall_q) begin
                check("stall_valid", out_valid0, 1);
                check("stall_data0", out_data0, held0);
                check("stall_data1", out_data1, held1);
            end
            if (out_valid0 && out_ready) begin
                if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e0 = exp_q0.pop_front();
                    e1 = exp_q1.pop_front();
                    check("out_data_off0", out_data0, e0[6:0]);
                    check("out_data_off1", out_data1, e1[6:0]);
                    check("out_last", out_last0, e0[7]);
                    check("out_last1", out_last1, e1[7]);
                    if (e0[7]) begin
                        after_last = 1;
                        edge_ctr   = 0;
                    end else begin
                        edge_ctr++;
                    end
                end
            end
            stall_q = out_valid0 && !out_ready;
            held0   = out_data0;
            held1   = out_data1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All positive, tie at 3.
        set_frame(5, 3, 9, 3, 7, 12, 0, 0, 0, 0, 0, 0);
        send_frame(0, DEG);
        wait_drain();

        // Mixed signs, with a forced stall on edge 2.
        set_frame(4, 8, 2, 6, 9, 5, 1, 0, 0, 1, 1, 0);
        bp_arm = 1;
        send_frame(0, DEG);
        wait_drain();

        // Offset clamps to zero.
        set_frame(1, 1, 6, 6, 6, 6, 0, 1, 0, 1, 1, 0);
        send_frame(0, DEG);
        wait_drain();

        // Gapped collection of the mixed-sign frame.
        set_frame(4, 8, 2, 6, 9, 5, 1, 0, 0, 1, 1, 0);
        send_frame(3, DEG);
        wait_drain();

        // Reset after 3 accepted beats, then a full fresh frame.
        set_frame(0, 1, 2, 30, 30, 30, 1, 1, 1, 0, 0, 0);
        send_frame(0, 3);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_frame(20, 17, 25, 32, 18, 19, 0, 1, 1, 0, 0, 1);
        send_frame(0, DEG);
        wait_drain();

        // Randomized frames with random gaps and backpressure.
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < DEG; j++) begin
                cur_mag[j] = (f % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 32);
                cur_sgn[j] = $urandom_range(0, 1);
            end
            send_frame(f % 2 == 0 ? 2 : 0, DEG);
        end
        wait_drain();
        rand_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
